mem_arbiter_cache: RTL and testbench

//  Shares one main-memory port between the instruction cache (read-only block refills)
//  and the data cache cache_dados (block refills and 64-bit write-through).

---
 rtl/mem_arbiter_cache.sv | 134 +++++++++++++
 tb/tb_mem_arbiter_cache.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_cache.sv
// mem_arbiter_cache: shares one main-memory port between the instruction cache
// (block refills) and the data cache (block refills and 64-bit write-through).
// Round-robin arbitration, one transaction in flight, registered memory-side
// outputs and a watchdog on the memory handshake.
module mem_arbiter_cache #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 64,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  i_address,
    input  logic               i_read,
    output logic               i_ready,
    output logic [BLOCK_W-1:0] i_rdata,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [WDATA_W-1:0] d_write_data,
    input  logic               d_read,
    input  logic               d_write,
    output logic               d_ready,
    output logic [BLOCK_W-1:0] d_rdata,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [WDATA_W-1:0] mem_write_data,
    output logic               mem_read_out,
    output logic               mem_write_out,
    input  logic [BLOCK_W-1:0] mem_block_read_data,
    input  logic               mem_ready,
    output logic               mem_error
);

    // Watchdog counter only has to hold values up to TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t          state;
    state_t          state_next;
    logic            last_grant_d;   // 0: icache was granted last, 1: dcache
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            req_i;
    logic            req_d;
    logic            grant_i;
    logic            grant_d;
    logic            timeout;
    logic            finish;

    // On a tie the requester that was not granted last wins.
    assign req_i   = i_read;
    assign req_d   = d_read | d_write;
    assign grant_d = req_d & (~req_i | ~last_grant_d);
    assign grant_i = req_i & ~grant_d;

    // mem_ready has priority over the watchdog in the same cycle.
    assign timeout = (TIMEOUT != 0) && !mem_ready && (wd_cnt == WD_LAST);
    assign finish  = mem_ready | timeout;

    assign i_ready   = (state == RESP_I);
    assign d_ready   = (state == RESP_D);
    assign mem_error = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = BUSY_D;
                else if (grant_i) state_next = BUSY_I;
            end
            BUSY_I:  if (finish) state_next = RESP_I;
            BUSY_D:  if (finish) state_next = RESP_D;
            RESP_I:  state_next = IDLE;
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side registers, grant history, watchdog and refill data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            last_grant_d   <= 1'b0;
            wd_cnt         <= '0;
            err_q          <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (grant_d) begin
                        mem_address    <= d_address;
                        mem_write_data <= d_write ? d_write_data : '0;
                        mem_write_out  <= d_write;
                        mem_read_out   <= ~d_write;
                        last_grant_d   <= 1'b1;
                    end else if (grant_i) begin
                        mem_address    <= i_address;
                        mem_write_data <= '0;
                        mem_read_out   <= 1'b1;
                        last_grant_d   <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (finish) begin
                        mem_read_out  <= 1'b0;
                        mem_write_out <= 1'b0;
                        err_q         <= timeout;
                        if (state == BUSY_I)
                            i_rdata <= (mem_ready && mem_read_out) ? mem_block_read_data : '0;
                        else
                            d_rdata <= (mem_ready && mem_read_out) ? mem_block_read_data : '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_cache.sv
// tb_mem_arbiter_cache: directed bench for mem_arbiter_cache with a small
// memory responder whose ready delay and enable are set per test.
module tb_mem_arbiter_cache;

    localparam int ADDR_W  = 32;
    localparam int WDATA_W = 64;
    localparam int BLOCK_W = 128;

    logic               clk;
    logic               reset;
    logic [ADDR_W-1:0]  i_address;
    logic               i_read;
    logic               i_ready;
    logic [BLOCK_W-1:0] i_rdata;
    logic [ADDR_W-1:0]  d_address;
    logic [WDATA_W-1:0] d_write_data;
    logic               d_read;
    logic               d_write;
    logic               d_ready;
    logic [BLOCK_W-1:0] d_rdata;
    logic [ADDR_W-1:0]  mem_address;
    logic [WDATA_W-1:0] mem_write_data;
    logic               mem_read_out;
    logic               mem_write_out;
    logic [BLOCK_W-1:0] mem_block_read_data;
    logic               mem_ready;
    logic               mem_error;

    int checks = 0;
    int errors = 0;

    // Memory responder controls and a record of the last transaction start.
    logic              mem_enable;
    int                mem_delay;
    int                busy_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [WDATA_W-1:0] last_data;
    logic              last_wr;

    mem_arbiter_cache #(
        .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .BLOCK_W(BLOCK_W), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_address(d_address), .d_write_data(d_write_data), .d_read(d_read),
        .d_write(d_write), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .mem_block_read_data(mem_block_read_data), .mem_ready(mem_ready),
        .mem_error(mem_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: raises mem_ready once the strobe has been up mem_delay cycles.
    initial begin
        mem_ready = 1'b0;
        busy_cnt  = 0;
        last_addr = '0;
        last_data = '0;
        last_wr   = 1'b0;
        forever begin
            @(negedge clk);
            check_val("strobe_excl", {127'd0, mem_read_out & mem_write_out}, 128'd0);
            if (mem_read_out || mem_write_out) begin
                if (busy_cnt == 0) begin
                    last_addr = mem_address;
                    last_data = mem_write_data;
                    last_wr   = mem_write_out;
                end
                mem_ready = mem_enable && (busy_cnt >= mem_delay);
                busy_cnt++;
            end else begin
                busy_cnt  = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Wait (bounded) for either ready pulse, sampling on falling edges.
    task automatic wait_ready(input int max_cyc, output int cyc, output logic gi, output logic gd);
        cyc = 0;
        gi  = 1'b0;
        gd  = 1'b0;
        while (cyc < max_cyc && !gi && !gd) begin
            @(negedge clk);
            cyc++;
            gi = i_ready;
            gd = d_ready;
        end
        if (!gi && !gd) check_val("ready_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int   cyc;
        int   seen;
        logic gi;
        logic gd;
        logic [127:0] blk;

        reset = 1'b0;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_write_data = '0; d_read = 1'b0; d_write = 1'b0;
        mem_block_read_data = '0;
        mem_enable = 1'b1;
        mem_delay  = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", {126'd0, i_ready, d_ready}, 128'd0);
        check_val("rst_strobes", {125'd0, mem_read_out, mem_write_out, mem_error}, 128'd0);
        check_val("rst_addr_data", {32'd0, mem_address, mem_write_data}, 128'd0);
        check_val("rst_rdata", i_rdata | d_rdata, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single icache refill with immediate ready
        blk = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222;
        mem_block_read_data = blk;
        i_address = 32'h10;
        i_read = 1'b1;
        @(negedge clk);
        check_val("t2_strobe_c1", {126'd0, mem_read_out, mem_write_out}, 128'd2);
        check_val("t2_addr_c1", {96'd0, mem_address}, 128'h10);
        check_val("t2_no_ready_c1", {127'd0, i_ready}, 128'd0);
        @(negedge clk);
        check_val("t2_ready_c2", {126'd0, i_ready, d_ready}, 128'd2);
        check_val("t2_rdata", i_rdata, blk);
        check_val("t2_strobe_c2", {127'd0, mem_read_out}, 128'd0);
        i_read = 1'b0;
        @(negedge clk);
        check_val("t2_ready_c3", {127'd0, i_ready}, 128'd0);

        // Reset asserted mid-BUSY_D
        mem_enable = 1'b0;
        d_address = 32'h55;
        d_read = 1'b1;
        @(negedge clk);
        check_val("t1_busy", {127'd0, mem_read_out}, 128'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("t1_async_strobes", {124'd0, mem_read_out, mem_write_out, mem_error, d_ready}, 128'd0);
        check_val("t1_async_addr", {96'd0, mem_address}, 128'd0);
        d_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem_enable = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_ready || mem_read_out) seen++;
        end
        check_val("t1_no_ready_after", 128'(seen), 128'd0);

        // Tie after reset goes to D, then I
        mem_delay = 0;
        mem_block_read_data = 128'h1111_0000_2222_0000_3333_0000_4444_0000;
        i_address = 32'h100; d_address = 32'h200;
        i_read = 1'b1; d_read = 1'b1;
        wait_ready(10, cyc, gi, gd);
        check_val("t3_first_d", {126'd0, gi, gd}, 128'd1);
        check_val("t3_first_addr", {96'd0, last_addr}, 128'h200);
        check_val("t3_d_rdata", d_rdata, 128'h1111_0000_2222_0000_3333_0000_4444_0000);
        d_read = 1'b0;
        wait_ready(10, cyc, gi, gd);
        check_val("t3_second_i", {126'd0, gi, gd}, 128'd2);
        check_val("t3_second_lat", 128'(cyc), 128'd3);
        check_val("t3_second_addr", {96'd0, last_addr}, 128'h100);
        i_read = 1'b0;
        @(negedge clk);

        // dcache write-through
        mem_block_read_data = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
        d_address = 32'h40;
        d_write_data = 64'h1234_5678_9ABC_DEF0;
        d_write = 1'b1;
        @(negedge clk);
        check_val("t4_strobes", {126'd0, mem_read_out, mem_write_out}, 128'd1);
        check_val("t4_addr", {96'd0, mem_address}, 128'h40);
        check_val("t4_data", {64'd0, mem_write_data}, 128'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        check_val("t4_ready", {126'd0, i_ready, d_ready}, 128'd1);
        check_val("t4_rdata_zero", d_rdata, 128'd0);
        d_write = 1'b0;
        @(negedge clk);
        check_val("t4_ready_once", {127'd0, d_ready}, 128'd0);

        // Tie after a D grant goes to I
        blk = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        mem_block_read_data = blk;
        i_address = 32'h300; d_address = 32'h400;
        i_read = 1'b1; d_read = 1'b1;
        wait_ready(10, cyc, gi, gd);
        check_val("t3b_first_i", {126'd0, gi, gd}, 128'd2);
        check_val("t3b_first_addr", {96'd0, last_addr}, 128'h300);
        i_read = 1'b0;
        wait_ready(10, cyc, gi, gd);
        check_val("t3b_second_d", {126'd0, gi, gd}, 128'd1);
        check_val("t3b_d_rdata", d_rdata, blk);
        d_read = 1'b0;
        @(negedge clk);

        // Watchdog timeout (TIMEOUT=4) with mem_ready held low
        mem_enable = 1'b0;
        d_address = 32'h80;
        d_read = 1'b1;
        wait_ready(12, cyc, gi, gd);
        check_val("t5_latency", 128'(cyc), 128'd5);
        check_val("t5_err_ready", {125'd0, mem_error, gi, gd}, 128'd5);
        check_val("t5_rdata_zero", d_rdata, 128'd0);
        check_val("t5_strobe_off", {127'd0, mem_read_out}, 128'd0);
        d_read = 1'b0;
        @(negedge clk);
        check_val("t5_pulse_end", {126'd0, mem_error, d_ready}, 128'd0);
        mem_enable = 1'b1;

        // D request and address changes during an icache transaction
        mem_delay = 2;
        blk = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        mem_block_read_data = blk;
        i_address = 32'h500;
        i_read = 1'b1;
        @(negedge clk);
        check_val("t6_i_granted", {96'd0, mem_address}, 128'h500);
        d_address = 32'hA00;
        d_read = 1'b1;
        @(negedge clk);
        d_address = 32'hB00;
        check_val("t6_hold_addr", {96'd0, mem_address}, 128'h500);
        check_val("t6_hold_op", {126'd0, mem_read_out, mem_write_out}, 128'd2);
        wait_ready(10, cyc, gi, gd);
        check_val("t6_i_done", {126'd0, gi, gd}, 128'd2);
        check_val("t6_i_rdata", i_rdata, blk);
        i_read = 1'b0;
        @(negedge clk);
        check_val("t6_idle_gap", {126'd0, mem_read_out, d_ready}, 128'd0);
        d_address = 32'hD00;
        @(negedge clk);
        check_val("t6_d_grant_addr", {96'd0, mem_address}, 128'hD00);
        check_val("t6_d_strobe", {127'd0, mem_read_out}, 128'd1);
        wait_ready(10, cyc, gi, gd);
        check_val("t6_d_done", {126'd0, gi, gd}, 128'd1);
        check_val("t6_d_rdata", d_rdata, blk);
        d_read = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
